// File: rtl/bp_update_ctrl_pkg.sv
// bp_update_ctrl_pkg: FSM state encoding, 2-bit counter constants and default widths
// shared by the branch-predictor update controller and its interface.
package bp_update_ctrl_pkg;
    localparam int PTIDX_D  = 8;
    localparam int BTBIDX_D = 4;
    localparam int TAGW_D   = 26;
    localparam int DW_D     = 32;
    localparam int QDEPTH_D = 4;
    localparam int STARVE_D = 4;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_MAX = 2'd3;
    typedef enum logic [1:0] {CLEAR, IDLE, UPD_RD, UPD_WR} state_e;
    function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic taken);
        return taken ? ((c == CTR_MAX) ? c : c + 2'd1) : ((c == 2'd0) ? c : c - 2'd1);
    endfunction
endpackage

// File: rtl/bp_update_ctrl_if.sv
// bp_update_ctrl_if: update/lookup handshakes and the shared PT/BTB table port.
interface bp_update_ctrl_if import bp_update_ctrl_pkg::*; #(
    parameter int PTIDX  = PTIDX_D,
    parameter int BTBIDX = BTBIDX_D,
    parameter int TAGW   = TAGW_D,
    parameter int DW     = DW_D
) ();
    logic              upd_valid, upd_ready, upd_taken;
    logic [PTIDX-1:0]  upd_pt_idx, lk_pt_idx, pt_addr, bhr;
    logic [BTBIDX-1:0] upd_btb_idx, lk_btb_idx, btb_addr;
    logic [TAGW-1:0]   upd_tag, btb_tag_wdata;
    logic [DW-1:0]     upd_target, btb_val_wdata;
    logic              lk_valid, lk_grant, lk_rvalid;
    logic              tbl_en, tbl_we, btb_we, init_done;
    logic [1:0]        pt_wdata, pt_rdata;
    modport slave (
        input  upd_valid, upd_pt_idx, upd_btb_idx, upd_taken, upd_tag, upd_target,
        input  lk_valid, lk_pt_idx, lk_btb_idx, pt_rdata,
        output upd_ready, lk_grant, lk_rvalid, tbl_en, tbl_we, pt_addr, pt_wdata,
        output btb_addr, btb_we, btb_tag_wdata, btb_val_wdata, bhr, init_done
    );
    modport master (
        output upd_valid, upd_pt_idx, upd_btb_idx, upd_taken, upd_tag, upd_target,
        output lk_valid, lk_pt_idx, lk_btb_idx, pt_rdata,
        input  upd_ready, lk_grant, lk_rvalid, tbl_en, tbl_we, pt_addr, pt_wdata,
        input  btb_addr, btb_we, btb_tag_wdata, btb_val_wdata, bhr, init_done
    );
endinterface

// File: rtl/bp_upd_fifo.sv
// bp_upd_fifo: small FIFO holding resolved-branch updates; count is registered so a
// pop only frees a slot for the producer on the following cycle.
module bp_upd_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;
    always_ff @(posedge clk)
        if (push) mem_q[wr_q] <= din;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + 1'b1;
            if (pop) rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
        end
    end
    assign dout  = mem_q[rd_q];
    assign count = cnt_q;
endmodule

// File: rtl/bp_update_ctrl.sv
// bp_update_ctrl: clears the PT/BTB after reset, then arbitrates the single table port
// between FE lookups and queued read-modify-write branch updates with starvation guard.
module bp_update_ctrl import bp_update_ctrl_pkg::*; #(
    parameter int PTIDX  = PTIDX_D,
    parameter int BTBIDX = BTBIDX_D,
    parameter int TAGW   = TAGW_D,
    parameter int DW     = DW_D,
    parameter int QDEPTH = QDEPTH_D,
    parameter int STARVE = STARVE_D
) (
    input logic             clk,
    input logic             reset,
    bp_update_ctrl_if.slave bus
);
    localparam int EW = PTIDX + BTBIDX + 1 + TAGW + DW;
    localparam int CW = $clog2(QDEPTH) + 1;
    localparam int SW = $clog2(STARVE + 1);
    state_e            state_q, state_d;
    logic [PTIDX-1:0]  clr_addr_q, clr_addr_d, bhr_q, bhr_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic              init_done_q, init_done_d, lk_rvalid_q;
    logic [1:0]        ctr_q;
    logic [CW-1:0]     count;
    logic              push, pop, q_empty, starved;
    logic [EW-1:0]     head;
    logic [PTIDX-1:0]  h_pt;
    logic [BTBIDX-1:0] h_btb;
    logic              h_taken;
    logic [TAGW-1:0]   h_tag;
    logic [DW-1:0]     h_tgt;
    assign {h_pt, h_btb, h_taken, h_tag, h_tgt} = head;
    assign q_empty        = count == '0;
    assign starved        = starve_q == SW'(STARVE);
    assign bus.upd_ready  = init_done_q && (count < CW'(QDEPTH));
    assign push           = bus.upd_valid && bus.upd_ready;
    assign bus.lk_rvalid  = lk_rvalid_q;
    assign bus.bhr        = bhr_q;
    assign bus.init_done  = init_done_q;
    bp_upd_fifo #(.W(EW), .DEPTH(QDEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   ({bus.upd_pt_idx, bus.upd_btb_idx, bus.upd_taken, bus.upd_tag, bus.upd_target}),
        .pop   (pop),
        .dout  (head),
        .count (count)
    );
    // Outputs are gated by reset so nothing reaches the tables while it is held.
    always_comb begin
        state_d           = state_q;
        clr_addr_d        = clr_addr_q;
        starve_d          = starve_q;
        bhr_d             = bhr_q;
        init_done_d       = init_done_q;
        pop               = 1'b0;
        bus.lk_grant      = 1'b0;
        bus.tbl_en        = 1'b0;
        bus.tbl_we        = 1'b0;
        bus.btb_we        = 1'b0;
        bus.pt_addr       = '0;
        bus.pt_wdata      = '0;
        bus.btb_addr      = '0;
        bus.btb_tag_wdata = '0;
        bus.btb_val_wdata = '0;
        if (reset) begin
            case (state_q)
                CLEAR: begin
                    bus.tbl_en   = 1'b1;
                    bus.tbl_we   = 1'b1;
                    bus.pt_addr  = clr_addr_q;
                    bus.pt_wdata = CTR_WNT;
                    bus.btb_addr = clr_addr_q[BTBIDX-1:0];
                    bus.btb_we   = (clr_addr_q >> BTBIDX) == '0;
                    clr_addr_d   = clr_addr_q + 1'b1;
                    state_d      = (&clr_addr_q) ? IDLE : CLEAR;
                    init_done_d  = &clr_addr_q;
                end
                IDLE: begin
                    if (bus.lk_valid && (q_empty || !starved)) begin
                        bus.lk_grant = 1'b1;
                        bus.tbl_en   = 1'b1;
                        bus.pt_addr  = bus.lk_pt_idx;
                        bus.btb_addr = bus.lk_btb_idx;
                        starve_d     = q_empty ? starve_q : starve_q + 1'b1;
                    end else if (!q_empty) begin
                        bus.tbl_en   = 1'b1;
                        bus.pt_addr  = h_pt;
                        bus.btb_addr = h_btb;
                        starve_d     = '0;
                        state_d      = UPD_RD;
                    end
                end
                UPD_RD: state_d = UPD_WR;
                UPD_WR: begin
                    bus.tbl_en        = 1'b1;
                    bus.tbl_we        = 1'b1;
                    bus.btb_we        = 1'b1;
                    bus.pt_addr       = h_pt;
                    bus.pt_wdata      = ctr_next(ctr_q, h_taken);
                    bus.btb_addr      = h_btb;
                    bus.btb_tag_wdata = h_tag;
                    bus.btb_val_wdata = h_tgt;
                    bhr_d             = {bhr_q[PTIDX-2:0], h_taken};
                    pop               = 1'b1;
                    state_d           = IDLE;
                end
                default: state_d = CLEAR;
            endcase
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= CLEAR;
            clr_addr_q  <= '0;
            starve_q    <= '0;
            bhr_q       <= '0;
            init_done_q <= 1'b0;
            lk_rvalid_q <= 1'b0;
            ctr_q       <= '0;
        end else begin
            state_q     <= state_d;
            clr_addr_q  <= clr_addr_d;
            starve_q    <= starve_d;
            bhr_q       <= bhr_d;
            init_done_q <= init_done_d;
            lk_rvalid_q <= bus.lk_grant;
            if (state_q == UPD_RD) ctr_q <= bus.pt_rdata;
        end
    end
endmodule
